// File: rtl/manch_tx_pkg.sv
// manch_tx_pkg: shared types and constants for the framed Manchester transmitter.
//   state_e            - transmitter FSM states
//   PREAMBLE_START_BIT - value of the first preamble bit (pattern alternates)
//   LINE_IDLE          - level driven on manch_out outside preamble/data
//   max3()             - elaboration-time helper for counter sizing
package manch_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    GAP
  } state_e;

  localparam logic PREAMBLE_START_BIT = 1'b1;
  localparam logic LINE_IDLE          = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/manch_halfbit_timer.sv
// manch_halfbit_timer: half-cycle counter for Manchester bit cells.
//   clk_i       in   clock
//   rst_ni      in   synchronous active-low reset
//   clr_i       in   force counter and half-select to 0 on the next edge
//   half_sel_o  out  0 = first half of the cell, 1 = second half
//   half_end_o  out  last cycle of the current half
//   cell_end_o  out  last cycle of the second half (end of the bit cell)
module manch_halfbit_timer #(
  parameter int HALF_BIT_CYC = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic half_sel_o,
  output logic half_end_o,
  output logic cell_end_o
);

  localparam int HCW = (HALF_BIT_CYC > 1) ? $clog2(HALF_BIT_CYC) : 1;
  localparam logic [HCW-1:0] HC_LAST = HCW'(HALF_BIT_CYC - 1);

  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic           half_q, half_d;

  assign half_end_o = (hcnt_q == HC_LAST);
  assign cell_end_o = half_end_o & half_q;
  assign half_sel_o = half_q;

  always_comb begin
    hcnt_d = half_end_o ? '0 : hcnt_q + HCW'(1);
    half_d = half_end_o ? ~half_q : half_q;
    if (clr_i) begin
      hcnt_d = '0;
      half_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      half_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      half_q <= half_d;
    end
  end

endmodule

// File: rtl/manchester_encoder_framed.sv
// manchester_encoder_framed: valid/ready word stream to framed Manchester line code
// (preamble, MSB-first words, idle gap). Logic 1 = high-then-low cell.
//   clk_240m   in   clock
//   rst_n      in   synchronous active-low reset
//   s_data     in   word to send
//   s_last     in   word is the final word of the frame
//   s_valid    in   s_data/s_last valid
//   s_ready    out  word accepted when s_valid && s_ready
//   manch_out  out  registered line output
//   manch_oe   out  registered driver enable (preamble and data only)
//   busy       out  FSM not idle
//   underrun   out  one-cycle pulse when a frame is aborted for lack of data
//
// state    | meaning
// IDLE     | waiting for the first word of a frame, s_ready high
// PREAMBLE | sending the alternating 1,0,1,0... preamble
// DATA     | shifting the latched word out MSB first
// GAP      | line idle, driver off, before returning to IDLE
module manchester_encoder_framed
  import manch_tx_pkg::*;
#(
  parameter int HALF_BIT_CYC  = 3,
  parameter int DATA_W        = 16,
  parameter int PREAMBLE_BITS = 8,
  parameter int GAP_BITS      = 2
) (
  input  logic              clk_240m,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              manch_out,
  output logic              manch_oe,
  output logic              busy,
  output logic              underrun
);

  localparam int BCW = $clog2(max3(DATA_W, PREAMBLE_BITS, GAP_BITS) + 1);
  localparam logic [BCW-1:0] PRE_LAST  = BCW'(PREAMBLE_BITS - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] GAP_LAST  = BCW'(GAP_BITS - 1);

  state_e            state_q, state_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              last_q, last_d;
  logic              underrun_q, underrun_d;
  logic              out_q, oe_q;
  logic              line_d, oe_d;

  logic clr, half_sel, half_end, cell_end, half_nxt, word_end;

  manch_halfbit_timer #(
    .HALF_BIT_CYC(HALF_BIT_CYC)
  ) u_timer (
    .clk_i      (clk_240m),
    .rst_ni     (rst_n),
    .clr_i      (clr),
    .half_sel_o (half_sel),
    .half_end_o (half_end),
    .cell_end_o (cell_end)
  );

  assign word_end = (state_q == DATA) && cell_end && (bit_q == DATA_LAST);
  assign s_ready  = rst_n && ((state_q == IDLE) || word_end);
  assign busy     = rst_n && (state_q != IDLE);
  assign clr      = (state_d != state_q) || (state_q == IDLE);
  // Half-select of the next cycle; the output register is loaded from the
  // next-state view so the line lines up with the state on the same cycle.
  assign half_nxt = clr ? 1'b0 : (half_sel ^ half_end);

  assign manch_out = out_q;
  assign manch_oe  = oe_q;
  assign underrun  = underrun_q;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    last_d     = last_q;
    underrun_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid && s_ready) begin
          shift_d = s_data;
          last_d  = s_last;
          bit_d   = '0;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (cell_end) begin
          if (bit_q == PRE_LAST) begin
            bit_d   = '0;
            state_d = DATA;
          end else begin
            bit_d = bit_q + BCW'(1);
          end
        end
      end
      DATA: begin
        if (word_end) begin
          bit_d = '0;
          if (s_valid) begin
            shift_d = s_data;
            last_d  = s_last;
          end else begin
            underrun_d = ~last_q;
            state_d    = GAP;
          end
        end else if (cell_end) begin
          bit_d   = bit_q + BCW'(1);
          shift_d = shift_q << 1;
        end
      end
      GAP: begin
        if (cell_end) begin
          if (bit_q == GAP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Second half of a cell is the complement of the first: b ^ half.
  always_comb begin
    line_d = LINE_IDLE;
    oe_d   = 1'b0;
    case (state_d)
      PREAMBLE: begin
        oe_d   = 1'b1;
        line_d = (PREAMBLE_START_BIT ^ bit_d[0]) ^ half_nxt;
      end
      DATA: begin
        oe_d   = 1'b1;
        line_d = shift_d[DATA_W-1] ^ half_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_240m) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
      out_q      <= LINE_IDLE;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      underrun_q <= underrun_d;
      out_q      <= line_d;
      oe_q       <= oe_d;
    end
  end

endmodule

// File: tb/tb_manchester_encoder_framed.sv
module tb_manchester_encoder_framed;

  localparam int H  = 3;
  localparam int DW = 16;
  localparam int PB = 8;
  localparam int GB = 2;
  localparam int C  = 2 * H;
  localparam int P  = PB * C;
  localparam int D  = DW * C;
  localparam int G  = GB * C;
  localparam int RAND_FRAMES = 80;
  localparam int RAND_BUDGET = 70000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready, manch_out, manch_oe, busy, underrun;

  int n_run = 0;
  int n_fail = 0;
  logic [DW-1:0] dir_w [8];

  manchester_encoder_framed #(
    .HALF_BIT_CYC(H), .DATA_W(DW), .PREAMBLE_BITS(PB), .GAP_BITS(GB)
  ) dut (
    .clk_240m (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .manch_out(manch_out),
    .manch_oe (manch_oe),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #990000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_run++;
      if ({manch_out, manch_oe, busy, underrun, s_ready} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: out/oe/busy/ur/rdy got %b want 00000", i,
                 {manch_out, manch_oe, busy, underrun, s_ready});
      end
    end
    rst_n = 1'b1;
    #1;
    n_run++;
    if ({s_ready, manch_out, manch_oe, busy, underrun} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_release: rdy/out/oe/busy/ur got %b want 10000",
               {s_ready, manch_out, manch_oe, busy, underrun});
    end
  endtask

  // Frame of n words (dir_w), of which the first m are supplied; m<n aborts.
  // Caller is on a cycle where the DUT is idle; that cycle is t=0.
  task automatic run_frame(input string name, input int n, input int m);
    int   e_cyc, t_last, i, ph, u, k, r, j;
    logic b, wend;
    logic [4:0] want, got;
    e_cyc  = P + m * D;
    t_last = e_cyc + G + 1;
    #1;
    for (int t = 0; t <= t_last; t++) begin
      if (t > 0) @(negedge clk);
      // want = {out, oe, busy, rdy, ur}
      want = 5'b00100;
      wend = 1'b0;
      k = 0;
      if (t == 0 || t == t_last) begin
        want = 5'b00010;
      end else if (t <= P) begin
        i  = (t - 1) / C;
        ph = (t - 1) % C;
        b  = (i % 2 == 0);
        want = {b ^ (ph >= H), 1'b1, 1'b1, 1'b0, 1'b0};
      end else if (t <= e_cyc) begin
        u  = t - P - 1;
        k  = u / D;
        r  = u % D;
        j  = r / C;
        ph = r % C;
        b  = dir_w[k][DW-1-j];
        wend = (r == D - 1);
        want = {b ^ (ph >= H), 1'b1, 1'b1, wend, 1'b0};
      end else begin
        want = {1'b0, 1'b0, 1'b1, 1'b0, (t == e_cyc + 1) && (m < n)};
      end
      got = {manch_out, manch_oe, busy, s_ready, underrun};
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s t=%0d: out/oe/busy/rdy/ur got %b want %b", name, t, got, want);
      end
      if (t == 0) begin
        s_valid = 1'b1; s_data = dir_w[0]; s_last = (n == 1);
      end else if (wend && (k + 1 < m)) begin
        s_valid = 1'b1; s_data = dir_w[k+1]; s_last = (k + 1 == n - 1);
      end else if (wend || t == t_last) begin
        s_valid = 1'b0;
      end else begin
        // Offered but must be ignored outside word-end.
        s_valid = 1'b1; s_data = DW'($urandom); s_last = 1'($urandom);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    dir_w[0] = 16'hA5C3;
    run_frame("single", 1, 1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    dir_w[0] = 16'hFFFF;
    dir_w[1] = 16'h0000;
    run_frame("back_to_back", 2, 2);
  endtask

  task automatic test_underrun();
    @(negedge clk);
    dir_w[0] = 16'h1234;
    dir_w[1] = 16'hBEEF;
    run_frame("underrun", 2, 1);
  endtask

  task automatic test_multi_word();
    @(negedge clk);
    for (int i = 0; i < 3; i++) dir_w[i] = DW'($urandom);
    run_frame("multi_word", 3, 3);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #1;
    s_valid = 1'b1; s_data = DW'($urandom); s_last = 1'b1;
    for (int t = 1; t <= 70; t++) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    n_run++;
    if ({manch_oe, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_mid_pre: oe/busy got %b want 11", {manch_oe, busy});
    end
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({s_ready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_asserted: rdy/busy got %b want 00", {s_ready, busy});
    end
    @(negedge clk);
    n_run++;
    if ({manch_out, manch_oe, busy, underrun, s_ready} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_mid_after: out/oe/busy/ur/rdy got %b want 00000",
               {manch_out, manch_oe, busy, underrun, s_ready});
    end
    rst_n = 1'b1;
    dir_w[0] = DW'($urandom);
    run_frame("after_reset", 1, 1);
  endtask

  task automatic test_random();
    int frames_left = RAND_FRAMES;
    int n = 0, lim = 0, idx = 0, idle_wait = 0;
    int stalls = 0, ur_seen = 0, cyc = 0;
    int len, nw, base;
    logic prev_oe = 1'b0;
    logic ok, b, e;
    logic [DW-1:0] cur [8];
    logic [DW-1:0] word, expw;
    logic [DW-1:0] exp_q [$];
    logic samp [$];
    while (cyc < RAND_BUDGET) begin
      @(negedge clk);
      cyc++;
      if (underrun === 1'b1) ur_seen++;
      if (manch_oe === 1'b1) begin
        samp.push_back(manch_out);
      end else if (prev_oe) begin
        // Decode the frame just finished purely from the line samples.
        len = samp.size();
        n_run++;
        if (len < P || ((len - P) % D) != 0) begin
          n_fail++;
          $display("FAIL rand_frame_len: got %0d samples want %0d + k*%0d", len, P, D);
        end
        ok = 1'b1;
        for (int i = 0; i < P && i < len; i++) begin
          e = ((i / C) % 2 == 0) ^ ((i % C) >= H);
          if (samp[i] !== e) ok = 1'b0;
        end
        n_run++;
        if (!ok) begin
          n_fail++;
          $display("FAIL rand_preamble: got corrupt pattern want 1,0,1,0...");
        end
        nw = (len >= P) ? (len - P) / D : 0;
        for (int w = 0; w < nw; w++) begin
          word = '0;
          ok = 1'b1;
          for (int j = 0; j < DW; j++) begin
            base = P + w * D + j * C;
            b = samp[base];
            for (int ph = 0; ph < C; ph++)
              if (samp[base+ph] !== (b ^ (ph >= H))) ok = 1'b0;
            word = (word << 1) | DW'(b);
          end
          n_run++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rand_word: got extra word %h want none", word);
          end else begin
            expw = exp_q.pop_front();
            if (!ok || word !== expw) begin
              n_fail++;
              $display("FAIL rand_word: got %h (cells ok=%b) want %h", word, ok, expw);
            end
          end
        end
        samp.delete();
      end
      prev_oe = manch_oe;

      if (s_ready && !busy) begin
        if (idx == lim) begin
          if (frames_left == 0) begin
            s_valid = 1'b0;
            break;
          end
          frames_left--;
          n = $urandom_range(1, 8);
          lim = n;
          if (n > 1 && $urandom_range(0, 3) == 0) lim = $urandom_range(1, n - 1);
          idx = 0;
          idle_wait = $urandom_range(0, 3);
          for (int i = 0; i < 8; i++) cur[i] = DW'($urandom);
        end
        if (idle_wait > 0) begin
          idle_wait--;
          s_valid = 1'b0;
        end else begin
          s_valid = 1'b1; s_data = cur[idx]; s_last = (idx == n - 1);
          exp_q.push_back(cur[idx]);
          idx++;
        end
      end else if (s_ready) begin
        if (idx < lim) begin
          s_valid = 1'b1; s_data = cur[idx]; s_last = (idx == n - 1);
          exp_q.push_back(cur[idx]);
          idx++;
        end else begin
          s_valid = 1'b0;
          if (lim < n) stalls++;
        end
      end else begin
        s_valid = 1'($urandom); s_data = DW'($urandom); s_last = 1'($urandom);
      end
    end
    s_valid = 1'b0;
    n_run++;
    if (cyc >= RAND_BUDGET || frames_left != 0) begin
      n_fail++;
      $display("FAIL rand_timeout: got %0d frames left want 0", frames_left);
    end
    n_run++;
    if (ur_seen != stalls) begin
      n_fail++;
      $display("FAIL rand_underrun_count: got %0d want %0d", ur_seen, stalls);
    end
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_words_left: got %0d undecoded want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_multi_word();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
